mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, meaning idle cycles inserted before each access (legal range 0..15).
REQ-002 Parameter ADDR_BITS, default 9, meaning word-address bits decoded (depth 2**ADDR_BITS words of 32 bits).
REQ-003 Port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 Port clear  input  1  meaning synchronous, active-high reset.
REQ-005 Port read  input  1  meaning read request from the datapath MAR/MDR side, sampled only in IDLE.
REQ-006 Port write  input  1  meaning write request, sampled only in IDLE.
REQ-007 Port address  input  32  meaning word address driven from MAR; only bits [ADDR_BITS-1:0] are decoded.
REQ-008 Port data_in  input  32  meaning write data driven from MDR.
REQ-009 Port data_out  output  32  meaning read data toward the MDR Mdatain path.
REQ-010 Port done  output  1  meaning one-cycle completion strobe for the accepted request.
REQ-011 Port busy  output  1  meaning high whenever the state is not IDLE.
REQ-012 Port error  output  1  meaning sticky flag for an illegal request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACCESS and DONE.
REQ-014 In IDLE, when exactly one of read or write is high at a rising edge, the block SHALL latch the operation, address[ADDR_BITS-1:0] and data_in, and load the wait counter with WAIT_STATES.
REQ-015 On acceptance the FSM SHALL go to WAIT when WAIT_STATES>0, otherwise directly to ACCESS.
REQ-016 The FSM SHALL stay in WAIT for exactly WAIT_STATES cycles, decrementing the counter each cycle, and then enter ACCESS.
REQ-017 ACCESS SHALL last one cycle: a write updates the array at the closing edge; a read loads data_out from the array at the closing edge.
REQ-018 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-019 Latency from the accepting edge to the first cycle with done=1 SHALL be WAIT_STATES+2 cycles.
REQ-020 data_out SHALL hold its value from the last completed read until the next read completes; writes SHALL NOT change data_out.
REQ-021 read or write asserted while busy=1 SHALL be ignored, with no queuing and no error.
REQ-022 read and write both high in IDLE SHALL set error, SHALL NOT be accepted, and SHALL leave the FSM in IDLE.
REQ-023 Address bits above ADDR_BITS-1 SHALL be ignored, so addresses wrap modulo the depth.
REQ-024 A read of a location that has never been written SHALL return the array's uninitialised content; benches SHALL NOT rely on that value.
REQ-025 A request accepted in the cycle immediately after DONE (back-to-back) SHALL be serviced with identical latency.

Reset
REQ-026 While clear=1 at a rising edge, the state SHALL become IDLE, the counter 0, data_out 0x00000000, done 0, busy 0 and error 0.
REQ-027 clear SHALL take priority over any request sampled at the same edge.
REQ-028 clear asserted during WAIT or ACCESS SHALL abort the operation with no done pulse; an aborted write SHALL NOT modify the array if clear is high at the ACCESS closing edge.
REQ-029 Array contents SHALL NOT be cleared by reset.

Structure
REQ-030 The state encodings (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, DONE=2'b11) and the default WAIT_STATES and ADDR_BITS values SHALL reside in the shared datapath definitions include file.
REQ-031 The storage SHALL be a single sub-module, mem_array (synchronous write, registered read, one port), instantiated once; the FSM and counter SHALL live in mem_responder.

Verification
REQ-032 Reset, then write address 0x5 with data 0x00000012 (WAIT_STATES=2) -> done high exactly 4 cycles after the accepting edge; busy high for cycles 1-4.
REQ-033 Read address 0x5 -> data_out=0x00000012 in the done cycle and held afterwards; then write address 0x205 with data 0x14 and read address 0x5 -> 0x00000014 (wrap-around).
REQ-034 read=1 and write=1 together in IDLE -> error=1, busy stays 0, no done; error clears only on clear.
REQ-035 Pulse write during WAIT of an ongoing read -> ignored: a single done is produced and the array is unchanged.
REQ-036 Assert clear during WAIT of a write of 0xDEADBEEF to 0x7 -> no done; data_out=0, and a later read of 0x7 returns the previous contents.
REQ-037 Rebuild with WAIT_STATES=0 and issue back-to-back reads on the cycle after each done -> done every 3 cycles with correct data each time.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared datapath definitions for the memory responder: FSM encodings,
// operation type and default geometry/timing parameters.
package mem_responder_pkg;

   localparam int unsigned DEF_WAIT_STATES = 2;
   localparam int unsigned DEF_ADDR_BITS   = 9;
   localparam int unsigned DATA_BITS       = 32;
   localparam int unsigned CNT_BITS        = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WAIT   = 2'b01,
      ST_ACCESS = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read data.
// The read register is cleared by reset; the array contents are not.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
   parameter int unsigned WIDTH     = DATA_BITS
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [WIDTH-1:0]     wr_data,
   output logic [WIDTH-1:0]     rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   // rd_data only moves on a completed read, so it holds between reads
   always_ff @(posedge clock) begin
      if (clear) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one read or write in IDLE, inserts
// WAIT_STATES idle cycles, performs the access, then strobes done.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
   parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        done,
   output logic        busy,
   output logic        error
);

   localparam logic [CNT_BITS-1:0] WAIT_INIT = CNT_BITS'(WAIT_STATES);

   state_e                state, state_nx;
   logic [CNT_BITS-1:0]   wait_cnt, wait_cnt_nx;
   logic                  accept;
   logic                  err_set;
   op_e                   op_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [31:0]           data_q;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^address[31:ADDR_BITS];

   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         error    <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (err_set) begin
            error <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clear && accept) begin
         op_q   <= write ? OP_WRITE : OP_READ;
         addr_q <= address[ADDR_BITS-1:0];
         data_q <= data_in;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      accept      = 1'b0;
      err_set     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (read ^ write) begin
               accept      = 1'b1;
               wait_cnt_nx = WAIT_INIT;
               state_nx    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end else if (read && write) begin
               err_set = 1'b1;
            end
         end
         ST_WAIT: begin
            // leave on the cycle the counter reaches its last wait cycle
            wait_cnt_nx = wait_cnt - 1'b1;
            if (wait_cnt <= 1) begin
               wait_cnt_nx = '0;
               state_nx    = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign mem_wr_en = (state == ST_ACCESS) && (op_q == OP_WRITE) && !clear;
   assign mem_rd_en = (state == ST_ACCESS) && (op_q == OP_READ);
   assign done      = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   mem_array #(
      .ADDR_BITS (ADDR_BITS),
      .WIDTH     (32)
   ) u_mem_array (
      .clock   (clock),
      .clear   (clear),
      .wr_en   (mem_wr_en),
      .rd_en   (mem_rd_en),
      .addr    (addr_q),
      .wr_data (data_q),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic on two
// builds (WAIT_STATES=2 and 0), checked against a countdown transaction model.
module tb_mem_responder;

   localparam int unsigned AB  = 9;
   localparam int unsigned WS0 = 2;
   localparam int unsigned WS1 = 0;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        clr  [2];
   logic        rd   [2];
   logic        wr   [2];
   logic [31:0] addr [2];
   logic [31:0] din  [2];
   logic [31:0] dout [2];
   logic        done [2];
   logic        busy [2];
   logic        err  [2];

   mem_responder #(.WAIT_STATES(WS0), .ADDR_BITS(AB)) dut (
      .clock(clock), .clear(clr[0]), .read(rd[0]), .write(wr[0]),
      .address(addr[0]), .data_in(din[0]), .data_out(dout[0]),
      .done(done[0]), .busy(busy[0]), .error(err[0])
   );

   mem_responder #(.WAIT_STATES(WS1), .ADDR_BITS(AB)) dut_nw (
      .clock(clock), .clear(clr[1]), .read(rd[1]), .write(wr[1]),
      .address(addr[1]), .data_in(din[1]), .data_out(dout[1]),
      .done(done[1]), .busy(busy[1]), .error(err[1])
   );

   int          vectors    = 0;
   int          miscompares = 0;
   int unsigned cyc        = 0;
   bit          cmp_en     = 1'b0;

   // Transaction model: m_rem counts cycles until the unit is idle again.
   int              m_rem   [2];
   bit              m_wr    [2];
   logic [AB-1:0]   m_addr  [2];
   logic [31:0]     m_data  [2];
   logic [31:0]     m_dout  [2];
   bit              m_known [2];
   bit              m_err   [2];
   logic [31:0]     m_mem   [int unsigned];
   int unsigned     mkey;

   function automatic int unsigned ws_of(int u);
      return (u == 0) ? WS0 : WS1;
   endfunction

   task automatic check(string name, int u, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s unit%0d t=%0t: got %h expected %h", name, u, $time, act, exp);
      end
   endtask

   always @(posedge clock) begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
         if (clr[u]) begin
            m_rem[u]   = 0;
            m_dout[u]  = '0;
            m_known[u] = 1'b1;
            m_err[u]   = 1'b0;
         end else if (m_rem[u] == 0) begin
            if (rd[u] != wr[u]) begin
               m_rem[u]  = int'(ws_of(u)) + 2;
               m_wr[u]   = wr[u];
               m_addr[u] = addr[u][AB-1:0];
               m_data[u] = din[u];
            end else if (rd[u]) begin
               m_err[u] = 1'b1;
            end
         end else begin
            m_rem[u]--;
            if (m_rem[u] == 1) begin
               mkey = u * (1 << AB) + int'(m_addr[u]);
               if (m_wr[u]) begin
                  m_mem[mkey] = m_data[u];
               end else if (m_mem.exists(mkey)) begin
                  m_dout[u]  = m_mem[mkey];
                  m_known[u] = 1'b1;
               end else begin
                  m_known[u] = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         for (int u = 0; u < 2; u++) begin
            check("done", u, 32'(done[u]), 32'(m_rem[u] == 1));
            check("busy", u, 32'(busy[u]), 32'(m_rem[u] != 0));
            check("error", u, 32'(err[u]), 32'(m_err[u]));
            if (m_known[u]) begin
               check("data_out", u, dout[u], m_dout[u]);
            end
         end
      end
   end

   task automatic req(int u, bit r, bit w, logic [31:0] a, logic [31:0] d);
      @(negedge clock);
      rd[u] = r; wr[u] = w; addr[u] = a; din[u] = d;
      @(negedge clock);
      rd[u] = 1'b0; wr[u] = 1'b0;
   endtask

   // Returns the 1-based cycle count after the accepting edge at which done rose.
   task automatic wait_done(int u, output int n);
      n = 1;
      while (!done[u] && n < 40) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic xact(int u, bit r, bit w, logic [31:0] a, logic [31:0] d, int exp_lat);
      int n;
      req(u, r, w, a, d);
      wait_done(u, n);
      check("latency", u, 32'(n), 32'(exp_lat));
   endtask

   task automatic count_done(int u, int cycles, output int nd);
      nd = 0;
      repeat (cycles) begin
         if (done[u]) nd++;
         @(negedge clock);
      end
   endtask

   task automatic rand_run(int u, int cycles);
      repeat (cycles) begin
         @(negedge clock);
         rd[u]   = ($urandom_range(0, 3) == 0);
         wr[u]   = ($urandom_range(0, 3) == 0);
         clr[u]  = ($urandom_range(0, 63) == 0);
         addr[u] = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 15));
         din[u]  = $urandom;
      end
      @(negedge clock);
      rd[u] = 1'b0; wr[u] = 1'b0; clr[u] = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   initial begin
      int n, nd;
      int unsigned t_prev;
      for (int u = 0; u < 2; u++) begin
         clr[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; din[u] = '0;
         m_rem[u] = 0; m_known[u] = 1'b0; m_err[u] = 1'b0; m_dout[u] = '0;
      end
      repeat (3) @(negedge clock);
      clr[0] = 1'b0; clr[1] = 1'b0;
      cmp_en = 1'b1;

      check("rst_data_out", 0, dout[0], 32'h0);
      check("rst_busy", 0, 32'(busy[0]), 32'h0);
      check("rst_done", 0, 32'(done[0]), 32'h0);
      check("rst_error", 0, 32'(err[0]), 32'h0);

      // write 0x5 <- 0x12, done 4 cycles after acceptance, busy cycles 1..4
      req(0, 1'b0, 1'b1, 32'h5, 32'h12);
      check("busy_c1", 0, 32'(busy[0]), 32'h1);
      wait_done(0, n);
      check("wr_latency", 0, 32'(n), 32'd4);
      check("busy_c4", 0, 32'(busy[0]), 32'h1);
      @(negedge clock);
      check("busy_c5", 0, 32'(busy[0]), 32'h0);

      xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 4);
      check("rd5", 0, dout[0], 32'h12);
      @(negedge clock);
      check("rd5_hold", 0, dout[0], 32'h12);
      xact(0, 1'b0, 1'b1, 32'h205, 32'h14, 4);
      check("wr205_keeps_dout", 0, dout[0], 32'h12);
      xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 4);
      check("rd5_wrap", 0, dout[0], 32'h14);

      // write pulse during WAIT of a read is ignored
      req(0, 1'b1, 1'b0, 32'h5, 32'h0);
      wr[0] = 1'b1; addr[0] = 32'h5; din[0] = 32'h99;
      @(negedge clock);
      wr[0] = 1'b0;
      count_done(0, 8, nd);
      check("single_done", 0, 32'(nd), 32'd1);
      xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 4);
      check("rd5_unchanged", 0, dout[0], 32'h14);

      // clear during WAIT of a write aborts it
      xact(0, 1'b0, 1'b1, 32'h7, 32'h77, 4);
      req(0, 1'b0, 1'b1, 32'h7, 32'hDEAD_BEEF);
      clr[0] = 1'b1;
      @(negedge clock);
      clr[0] = 1'b0;
      count_done(0, 6, nd);
      check("abort_no_done", 0, 32'(nd), 32'd0);
      check("abort_data_out", 0, dout[0], 32'h0);
      xact(0, 1'b1, 1'b0, 32'h7, 32'h0, 4);
      check("rd7_prev", 0, dout[0], 32'h77);

      // read+write together: sticky error, not accepted
      @(negedge clock);
      rd[0] = 1'b1; wr[0] = 1'b1;
      @(negedge clock);
      rd[0] = 1'b0; wr[0] = 1'b0;
      check("err_set", 0, 32'(err[0]), 32'h1);
      check("err_busy", 0, 32'(busy[0]), 32'h0);
      count_done(0, 4, nd);
      check("err_no_done", 0, 32'(nd), 32'd0);
      xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 4);
      check("err_sticky", 0, 32'(err[0]), 32'h1);
      @(negedge clock);
      clr[0] = 1'b1;
      @(negedge clock);
      clr[0] = 1'b0;
      check("err_cleared", 0, 32'(err[0]), 32'h0);

      // zero-wait build: back-to-back reads, done every 3 cycles
      for (int i = 0; i < 4; i++) begin
         xact(1, 1'b0, 1'b1, 32'd10 + 32'(i), 32'hA500_0000 + 32'(i), 2);
      end
      req(1, 1'b1, 1'b0, 32'd10, 32'h0);
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_done(1, n);
         check("b2b_latency", 1, 32'(n), 32'd2);
         if (i > 0) check("b2b_period", 1, 32'(cyc - t_prev), 32'd3);
         t_prev = cyc;
         check("b2b_data", 1, dout[1], 32'hA500_0000 + 32'(i));
         if (i < 3) req(1, 1'b1, 1'b0, 32'd11 + 32'(i), 32'h0);
      end

      rand_run(0, 1500);
      rand_run(1, 1500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
